// File: rtl/kamacore_datatypes.sv
// Shared types for the kamacore fetch path: default widths, fetch-buffer FSM
// states and the {pc, instruction} entry layout.
package kamacore_datatypes;

    localparam int ADDR_WIDTH = 32;
    localparam int CPU_WIDTH  = 32;

    typedef enum logic [1:0] {
        FB_BOOT    = 2'd0,
        FB_RUN     = 2'd1,
        FB_DISCARD = 2'd2
    } fb_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [CPU_WIDTH-1:0]  instruction;
    } fb_entry_t;

endpackage

// File: rtl/kamacore_fifo.sv
// Generic synchronous FIFO with flush. Push while full is accepted only when
// a pop happens in the same cycle.
module kamacore_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
            rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
            count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/kamacore_fetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches under a credit limit,
// queues in-order responses for IF and squashes old-path responses on redirect.
module kamacore_fetch_buffer #(
    parameter int                    DEPTH       = 4,
    parameter int                    ADDR_WIDTH  = kamacore_datatypes::ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = kamacore_datatypes::CPU_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [ADDR_WIDTH-1:0]  if_pc,
    output logic [INSTR_WIDTH-1:0] if_instruction
);
    import kamacore_datatypes::*;

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_WIDTH + INSTR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    fb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      discard_cnt_q, discard_cnt_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [ENTRY_W-1:0]    fifo_wdata, fifo_rdata;
    logic                  credit_ok, req_fire;

    // Every in-flight request owns a FIFO slot, so a response can always be stored.
    assign credit_ok      = (int'(fifo_count) + int'(outstanding_q)) < DEPTH;
    assign imem_req_valid = (state_q == FB_RUN) && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign fifo_push  = imem_rsp_valid && !redirect_valid && (state_q == FB_RUN);
    assign fifo_wdata = {rsp_pc_q, imem_rsp_data};
    assign if_valid   = !fifo_empty && !redirect_valid;
    assign fifo_pop   = if_valid && if_ready;

    assign if_pc          = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1 -: ADDR_WIDTH];
    assign if_instruction = fifo_empty ? '0 : fifo_rdata[INSTR_WIDTH-1:0];

    kamacore_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .flush (redirect_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        discard_cnt_d = discard_cnt_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        if (redirect_valid) begin
            // Whatever is still in flight after this cycle belongs to the old path.
            fetch_pc_d    = redirect_pc;
            rsp_pc_d      = redirect_pc;
            discard_cnt_d = outstanding_d;
            state_d       = (outstanding_d != '0) ? FB_DISCARD : FB_RUN;
        end else begin
            if (req_fire)  fetch_pc_d = fetch_pc_q + PC_STEP;
            if (fifo_push) rsp_pc_d   = rsp_pc_q + PC_STEP;
            case (state_q)
                FB_BOOT: state_d = FB_RUN;
                FB_DISCARD: begin
                    if (imem_rsp_valid) begin
                        discard_cnt_d = discard_cnt_q - CNT_W'(1);
                        if (discard_cnt_d == '0) state_d = FB_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FB_BOOT;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_kamacore_fetch_buffer.sv
// Scoreboard bench for kamacore_fetch_buffer: a latency-programmable memory model
// answers requests, and IF-side output is checked against the issued address stream.
module tb_kamacore_fetch_buffer;
    import kamacore_datatypes::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_instruction;

    kamacore_fetch_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instruction(if_instruction)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;

    mreq_t       memq[$];
    fb_entry_t   expq[$];
    logic [31:0] fire_log[$], ifpc_log[$];
    logic [31:0] nxt_addr, prev_addr, obs_req_addr, drv_redir_pc;
    logic        drv_rst, drv_req_ready, drv_if_ready, drv_redir;
    logic        obs_req_valid, obs_if_valid, prev_stall;
    int          mem_lat, cyc, n_cmp, n_bad;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
    endfunction

    // One clock: drive at negedge, observe 1ns later, and update memory model and scoreboard.
    task automatic step_cycle();
        mreq_t m;
        fb_entry_t e;
        @(negedge clk);
        rst = drv_rst; imem_req_ready = drv_req_ready; if_ready = drv_if_ready;
        redirect_valid = drv_redir; redirect_pc = drv_redir_pc;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        if (drv_rst && memq.size() > 0 && memq[0].due <= cyc) begin
            m = memq.pop_front();
            imem_rsp_valid = 1'b1; imem_rsp_data = instr_of(m.addr);
        end
        #1;
        obs_req_valid = imem_req_valid; obs_if_valid = if_valid; obs_req_addr = imem_req_addr;
        if (drv_rst) begin
            if (prev_stall && !drv_redir) begin
                n_cmp++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
                    n_bad++; $display("FAIL req_hold: valid=%b addr=%h, need valid=1 addr=%h", imem_req_valid, imem_req_addr, prev_addr);
                end
            end
            if (drv_redir) begin
                n_cmp++;
                if (if_valid !== 1'b0) begin n_bad++; $display("FAIL if_valid_on_redirect: got %b want 0", if_valid); end
            end
            if (imem_req_valid && imem_req_ready) begin
                n_cmp++;
                if (imem_req_addr !== nxt_addr) begin n_bad++; $display("FAIL req_addr: got %h want %h", imem_req_addr, nxt_addr); end
                memq.push_back('{imem_req_addr, cyc + mem_lat});
                fire_log.push_back(imem_req_addr);
                if (!drv_redir) expq.push_back('{pc: nxt_addr, instruction: instr_of(nxt_addr)});
                nxt_addr = nxt_addr + 32'd4;
            end
            if (if_valid && if_ready) begin
                ifpc_log.push_back(if_pc);
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++; $display("FAIL if_stale: got pc %h with no expected entry", if_pc);
                end else begin
                    e = expq.pop_front();
                    if (if_pc !== e.pc || if_instruction !== e.instruction) begin
                        n_bad++; $display("FAIL if_data: got %h/%h want %h/%h", if_pc, if_instruction, e.pc, e.instruction);
                    end
                end
            end
            if (drv_redir) begin expq.delete(); nxt_addr = drv_redir_pc; end
            prev_stall = imem_req_valid && !imem_req_ready; prev_addr = imem_req_addr;
        end else begin
            prev_stall = 1'b0;
        end
        cyc++;
    endtask

    // Holds reset two cycles, clears models; the next step_cycle is cycle 0 after release.
    task automatic do_reset();
        drv_rst = 1'b0; drv_redir = 1'b0;
        step_cycle(); step_cycle();
        memq.delete(); expq.delete(); fire_log.delete(); ifpc_log.delete();
        nxt_addr = 32'h0;
        drv_rst = 1'b1;
    endtask

    task automatic test_reset();
        drv_rst = 1'b0; drv_req_ready = 1'b0; drv_if_ready = 1'b1;
        step_cycle();
        n_cmp++;
        if ({imem_req_valid, if_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_valids: got %b want 00", {imem_req_valid, if_valid}); end
        n_cmp++;
        if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", imem_req_addr); end
        n_cmp++;
        if (if_pc !== 32'h0 || if_instruction !== 32'h0) begin n_bad++; $display("FAIL reset_if: got %h/%h want 0/0", if_pc, if_instruction); end
        do_reset();
        step_cycle();
        n_cmp++;
        if (obs_req_valid !== 1'b0) begin n_bad++; $display("FAIL boot_no_req: got %b want 0", obs_req_valid); end
        step_cycle();
        n_cmp++;
        if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h0) begin
            n_bad++; $display("FAIL first_req: got %b/%h want 1/0", obs_req_valid, obs_req_addr);
        end
    endtask

    task automatic test_stream();
        do_reset();
        mem_lat = 1; drv_req_ready = 1'b1; drv_if_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step_cycle();
            n_cmp++;
            if (obs_if_valid !== (k >= 3)) begin n_bad++; $display("FAIL stream_if_valid c%0d: got %b want %b", k, obs_if_valid, k >= 3); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_lat = 1; drv_req_ready = 1'b1; drv_if_ready = 1'b0;
        for (int k = 0; k < 12; k++) step_cycle();
        n_cmp++;
        if (fire_log.size() != 4) begin n_bad++; $display("FAIL bp_req_count: got %0d want 4", fire_log.size()); end
        n_cmp++;
        if (obs_req_valid !== 1'b0 || obs_if_valid !== 1'b1) begin
            n_bad++; $display("FAIL bp_stalled: req_valid=%b if_valid=%b want 0/1", obs_req_valid, obs_if_valid);
        end
        drv_if_ready = 1'b1;
        for (int k = 0; k < 12; k++) step_cycle();
        n_cmp++;
        if (ifpc_log.size() < 8) begin n_bad++; $display("FAIL bp_drain: got %0d entries want >= 8", ifpc_log.size()); end
        for (int i = 0; i < ifpc_log.size(); i++) begin
            n_cmp++;
            if (ifpc_log[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, ifpc_log[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        mem_lat = 3; drv_if_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            drv_req_ready = (k != 3);
            drv_redir = (k == 3); drv_redir_pc = 32'h100;
            step_cycle();
            drv_redir = 1'b0;
            if (k >= 3 && k <= 5) begin
                n_cmp++;
                if (obs_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_no_req c%0d: got %b want 0", k, obs_req_valid); end
            end
            if (k == 6) begin
                n_cmp++;
                if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h100) begin
                    n_bad++; $display("FAIL redir_restart: got %b/%h want 1/00000100", obs_req_valid, obs_req_addr);
                end
            end
            if (k < 10) begin
                n_cmp++;
                if (obs_if_valid !== 1'b0) begin n_bad++; $display("FAIL redir_if_quiet c%0d: got %b want 0", k, obs_if_valid); end
            end
        end
        n_cmp++;
        if (ifpc_log.size() == 0 || ifpc_log[0] !== 32'h100) begin
            n_bad++; $display("FAIL redir_first_pc: got %0d entries, want first pc 00000100", ifpc_log.size());
        end
    endtask

    task automatic test_redirect_same_cycle();
        int base;
        do_reset();
        mem_lat = 2; drv_req_ready = 1'b1; drv_if_ready = 1'b1; base = 0;
        for (int k = 0; k < 16; k++) begin
            drv_redir = (k == 6); drv_redir_pc = 32'h200;
            step_cycle();
            drv_redir = 1'b0;
            if (k == 6) begin
                base = ifpc_log.size();
                n_cmp++;
                if (imem_rsp_valid !== 1'b1 || obs_req_valid !== 1'b0) begin
                    n_bad++; $display("FAIL same_cycle_redir: rsp=%b req_valid=%b want 1/0", imem_rsp_valid, obs_req_valid);
                end
            end
            if (k == 7) begin
                n_cmp++;
                if (obs_req_valid !== 1'b0) begin n_bad++; $display("FAIL same_cycle_discard: req_valid got %b want 0", obs_req_valid); end
            end
            if (k == 8) begin
                n_cmp++;
                if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h200) begin
                    n_bad++; $display("FAIL same_cycle_restart: got %b/%h want 1/00000200", obs_req_valid, obs_req_addr);
                end
            end
        end
        n_cmp++;
        if (ifpc_log.size() <= base || ifpc_log[base] !== 32'h200) begin
            n_bad++; $display("FAIL same_cycle_first_pc: log size %0d base %0d, want pc 00000200", ifpc_log.size(), base);
        end
    endtask

    task automatic test_wrap();
        int fbase, ibase;
        do_reset();
        mem_lat = 1; drv_req_ready = 1'b1; drv_if_ready = 1'b1; fbase = 0; ibase = 0;
        for (int k = 0; k < 14; k++) begin
            drv_redir = (k == 4); drv_redir_pc = 32'hFFFF_FFFC;
            step_cycle();
            drv_redir = 1'b0;
            if (k == 4) begin fbase = fire_log.size(); ibase = ifpc_log.size(); end
        end
        n_cmp++;
        if (fire_log.size() < fbase + 3 || fire_log[fbase] !== 32'hFFFF_FFFC || fire_log[fbase+1] !== 32'h0 || fire_log[fbase+2] !== 32'h4) begin
            n_bad++; $display("FAIL wrap_req: want FFFFFFFC,0,4 after redirect (log size %0d)", fire_log.size());
        end
        n_cmp++;
        if (ifpc_log.size() < ibase + 3 || ifpc_log[ibase] !== 32'hFFFF_FFFC || ifpc_log[ibase+1] !== 32'h0 || ifpc_log[ibase+2] !== 32'h4) begin
            n_bad++; $display("FAIL wrap_if: want FFFFFFFC,0,4 after redirect (log size %0d)", ifpc_log.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_lat = 3; drv_req_ready = 1'b1; drv_if_ready = 1'b0;
        for (int k = 0; k < 7; k++) step_cycle();
        n_cmp++;
        if (obs_if_valid !== 1'b1 || memq.size() == 0) begin
            n_bad++; $display("FAIL mid_setup: if_valid=%b pending=%0d want 1/>0", obs_if_valid, memq.size());
        end
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req_valid, if_valid} !== 2'b00 || imem_req_addr !== 32'h0 || if_pc !== 32'h0 || if_instruction !== 32'h0) begin
            n_bad++; $display("FAIL mid_async_reset: got %b%b %h %h %h want 00 0 0 0", imem_req_valid, if_valid, imem_req_addr, if_pc, if_instruction);
        end
        do_reset();
        mem_lat = 1; drv_if_ready = 1'b1;
        for (int k = 0; k < 10; k++) step_cycle();
        n_cmp++;
        if (fire_log.size() == 0 || fire_log[0] !== 32'h0 || ifpc_log.size() < 5 || ifpc_log[0] !== 32'h0) begin
            n_bad++; $display("FAIL mid_restart: fires=%0d ifs=%0d, want restart at 0", fire_log.size(), ifpc_log.size());
        end
    endtask

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
        drv_rst = 1'b0; drv_req_ready = 1'b0; drv_if_ready = 1'b0; drv_redir = 1'b0; drv_redir_pc = '0;
        mem_lat = 1; cyc = 0; n_cmp = 0; n_bad = 0; nxt_addr = '0; prev_addr = '0; prev_stall = 1'b0;
        obs_req_valid = 1'b0; obs_if_valid = 1'b0; obs_req_addr = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_same_cycle();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
